// File: rtl/trigger_hls_stall_pkg.sv
// Shared types and helpers for the AXI-Stream stall detector: channel state,
// blocked-condition decode and stall-counter width.
package trigger_hls_stall_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_BLOCKED = 2'd2
  } stall_state_e;

  // Inputs block when the kernel waits for data; outputs block on back-pressure.
  function automatic logic cond(input logic tvalid, input logic tready, input logic is_input);
    return is_input ? (tready & ~tvalid) : (tvalid & ~tready);
  endfunction

  function automatic int stall_cnt_w(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/trigger_hls_stall_chan.sv
// One watched channel: RUN/PENDING/BLOCKED tracker with a consecutive-stall
// counter, reporting BLOCKED and transitions into it.
module trigger_hls_stall_chan
  import trigger_hls_stall_pkg::*;
#(
  parameter int STALL_THRESH = 1024,
  parameter bit IS_INPUT     = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic tvalid,
  input  logic tready,
  output logic blocked,
  output logic blocked_nxt,
  output logic new_entry
);

  localparam int CW = stall_cnt_w(STALL_THRESH);
  localparam logic [CW-1:0] THRESH = CW'(STALL_THRESH);
  localparam logic [CW-1:0] ONE    = CW'(1);

  stall_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          cond_i;

  assign cond_i  = cond(tvalid, tready, IS_INPUT);
  assign cnt_inc = cnt_q + ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (cond_i) begin
            cnt_d   = ONE;
            state_d = (ONE >= THRESH) ? ST_BLOCKED : ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (cond_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == THRESH) state_d = ST_BLOCKED;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_BLOCKED: begin
          // Counter parks at THRESH while the stall persists.
          if (!cond_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    blocked     = (state_q == ST_BLOCKED);
    blocked_nxt = (state_d == ST_BLOCKED);
    new_entry   = blocked_nxt & ~blocked;
  end

endmodule

// File: rtl/trigger_hls_axis_stall_detect.sv
// Per-channel AXI-Stream stall detector feeding the deadlock monitor, with a
// first-offender capture and a saturating stall-event counter.
module trigger_hls_axis_stall_detect
  import trigger_hls_stall_pkg::*;
#(
  parameter int                NUM_CH       = 2,
  parameter logic [NUM_CH-1:0] CH_IS_INPUT  = 2'b01,
  parameter int                STALL_THRESH = 1024,
  parameter int                CNT_W        = 16
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic [NUM_CH-1:0]                          ch_tvalid,
  input  logic [NUM_CH-1:0]                          ch_tready,
  input  logic                                       clear_stats,
  output logic [NUM_CH-1:0]                          axis_block_sigs,
  output logic                                       stall_any,
  output logic                                       first_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_ch,
  output logic [CNT_W-1:0]                           stall_events
);

  localparam int FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] EV_MAX = '1;

  logic [NUM_CH-1:0] blocked, blocked_nxt, new_entry;
  logic              any_new;
  logic [FCH_W-1:0]  first_idx;

  logic              stall_any_q, stall_any_d;
  logic              first_valid_q, first_valid_d;
  logic [FCH_W-1:0]  first_ch_q, first_ch_d;
  logic [CNT_W-1:0]  stall_events_q, stall_events_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    trigger_hls_stall_chan #(
      .STALL_THRESH(STALL_THRESH),
      .IS_INPUT    (CH_IS_INPUT[g])
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .tvalid     (ch_tvalid[g]),
      .tready     (ch_tready[g]),
      .blocked    (blocked[g]),
      .blocked_nxt(blocked_nxt[g]),
      .new_entry  (new_entry[g])
    );
  end

  // Lowest-index new entry wins the capture.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (new_entry[i]) first_idx = FCH_W'(i);
    end
  end

  assign any_new = |new_entry;

  always_comb begin
    stall_any_d    = |blocked_nxt;
    first_valid_d  = first_valid_q;
    first_ch_d     = first_ch_q;
    stall_events_d = stall_events_q;
    if (clear_stats) begin
      first_valid_d  = 1'b0;
      first_ch_d     = '0;
      stall_events_d = '0;
    end
    // Applied after the clear so a coincident new entry is not lost.
    if (any_new) begin
      if (stall_events_d != EV_MAX) stall_events_d = stall_events_d + 1'b1;
      if (!first_valid_d) begin
        first_valid_d = 1'b1;
        first_ch_d    = first_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_any_q    <= 1'b0;
      first_valid_q  <= 1'b0;
      first_ch_q     <= '0;
      stall_events_q <= '0;
    end else begin
      stall_any_q    <= stall_any_d;
      first_valid_q  <= first_valid_d;
      first_ch_q     <= first_ch_d;
      stall_events_q <= stall_events_d;
    end
  end

  assign axis_block_sigs = blocked;
  assign stall_any       = stall_any_q;
  assign first_valid     = first_valid_q;
  assign first_ch        = first_ch_q;
  assign stall_events    = stall_events_q;

endmodule
